// File: rtl/jump_physics.sv
// jump_physics: tick-divided jump/gravity integrator for the dino sprite.
// Produces a saturating height, the velocity, airborne/ducking flags and a landing strobe.
module jump_physics #(
  parameter int TICK_DIV = 100000,
  parameter int POS_W    = 24,
  parameter int VEL_W    = 16,
  parameter int V_JUMP   = 1200,
  parameter int G_NORM   = 2,
  parameter int G_HOLD   = 1,
  parameter int G_DIVE   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    BTNU,
  input  logic                    BTND,
  output logic signed [POS_W-1:0] pos,
  output logic signed [VEL_W-1:0] vel,
  output logic                    airborne,
  output logic                    ducking,
  output logic                    land_pulse
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  // Wide enough that pos+vel can never overflow before the range checks.
  localparam int SUM_W = ((POS_W > VEL_W) ? POS_W : VEL_W) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_AIR    = 2'd2;

  localparam logic signed [SUM_W-1:0] POS_MAX  = {{(SUM_W-POS_W+1){1'b0}}, {(POS_W-1){1'b1}}};
  localparam logic signed [VEL_W:0]   VEL_MIN  = {2'b11, {(VEL_W-1){1'b0}}};
  localparam logic signed [VEL_W-1:0] V_JUMP_V = VEL_W'(V_JUMP);
  localparam logic signed [VEL_W:0]   G_NORM_V = (VEL_W+1)'(G_NORM);
  localparam logic signed [VEL_W:0]   G_HOLD_V = (VEL_W+1)'(G_HOLD);
  localparam logic signed [VEL_W:0]   G_DIVE_V = (VEL_W+1)'(G_DIVE);

  logic [CNT_W-1:0]        r_cnt;
  logic                    r_btnu_prev;
  logic [1:0]              r_state;
  logic signed [POS_W-1:0] r_pos;
  logic signed [VEL_W-1:0] r_vel;
  logic                    r_air;
  logic                    r_duck;
  logic                    r_land;

  logic                    w_tick;
  logic                    w_jump;
  logic                    w_vel_pos;
  logic signed [VEL_W:0]   w_g;
  logic signed [SUM_W-1:0] w_pos_sum;
  logic signed [VEL_W:0]   w_vel_diff;
  logic signed [VEL_W-1:0] w_vel_sat;
  logic [1:0]              w_state_n;
  logic signed [POS_W-1:0] w_pos_n;
  logic signed [VEL_W-1:0] w_vel_n;
  logic                    w_land_n;

  assign w_tick    = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign w_jump    = BTNU & ~r_btnu_prev;
  assign w_vel_pos = !r_vel[VEL_W-1] && (r_vel != '0);

  always_comb begin
    w_g        = G_NORM_V;
    w_pos_sum  = SUM_W'(r_pos) + SUM_W'(r_vel);
    w_vel_diff = (VEL_W+1)'(r_vel) - w_g;
    w_vel_sat  = r_vel;
    w_state_n  = r_state;
    w_pos_n    = r_pos;
    w_vel_n    = r_vel;
    w_land_n   = 1'b0;

    if (BTND) begin
      w_g = G_DIVE_V;
    end else if (BTNU && w_vel_pos) begin
      w_g = G_HOLD_V;
    end else begin
      w_g = G_NORM_V;
    end
    w_vel_diff = (VEL_W+1)'(r_vel) - w_g;

    if (w_vel_diff < VEL_MIN) begin
      w_vel_sat = VEL_MIN[VEL_W-1:0];
    end else begin
      w_vel_sat = w_vel_diff[VEL_W-1:0];
    end

    case (r_state)
      S_IDLE: begin
        if (w_jump) begin
          w_state_n = S_LAUNCH;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_LAUNCH: begin
        w_state_n = S_AIR;
        w_pos_n   = '0;
        w_vel_n   = V_JUMP_V;
      end
      S_AIR: begin
        // Integration uses the velocity from before this tick's gravity step.
        if (!w_tick) begin
          w_state_n = S_AIR;
        end else if (w_pos_sum[SUM_W-1] || (w_pos_sum == '0)) begin
          w_state_n = S_IDLE;
          w_pos_n   = '0;
          w_vel_n   = '0;
          w_land_n  = 1'b1;
        end else if (w_pos_sum > POS_MAX) begin
          w_pos_n = POS_MAX[POS_W-1:0];
          w_vel_n = w_vel_sat;
        end else begin
          w_pos_n = w_pos_sum[POS_W-1:0];
          w_vel_n = w_vel_sat;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_pos_n   = '0;
        w_vel_n   = '0;
      end
    endcase
  end

  // btnu_prev resets high so a button held through reset cannot look like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_btnu_prev <= 1'b1;
      r_state     <= S_IDLE;
      r_pos       <= '0;
      r_vel       <= '0;
      r_air       <= 1'b0;
      r_duck      <= 1'b0;
      r_land      <= 1'b0;
    end else begin
      r_cnt       <= w_tick ? '0 : (r_cnt + CNT_W'(1'b1));
      r_btnu_prev <= BTNU;
      r_state     <= w_state_n;
      r_pos       <= w_pos_n;
      r_vel       <= w_vel_n;
      r_air       <= (w_state_n != S_IDLE);
      r_duck      <= BTND & (w_state_n == S_IDLE);
      r_land      <= w_land_n;
    end
  end

  assign pos        = r_pos;
  assign vel        = r_vel;
  assign airborne   = r_air;
  assign ducking    = r_duck;
  assign land_pulse = r_land;

endmodule

// File: tb/tb_jump_physics.sv
// Bench for jump_physics: a cycle-level flight model checked every cycle, plus literal
// per-tick trajectories for tap, hold, dive, clamp and mid-flight reset.
module tb_jump_physics;

  typedef struct packed {
    int tdiv; int pmax; int vjump; int gn; int gh; int gd; int vmin;
  } mparam_t;

  typedef struct packed {
    int     phase;  // 0 ground, 1 launching, 2 flying
    longint pos;
    longint vel;
    int     cyc;
    bit     prev;
    bit     air;
    bit     duck;
    bit     land;
    bit     ev;     // a flight tick was applied this cycle
  } mstate_t;

  localparam mparam_t P  = '{tdiv: 4, pmax: 8388607, vjump: 6,  gn: 2, gh: 1, gd: 4, vmin: -32768};
  localparam mparam_t P5 = '{tdiv: 4, pmax: 31,      vjump: 20, gn: 1, gh: 1, gd: 1, vmin: -32768};

  logic clk = 1'b0;
  logic rst, btnu, btnd, btnu5;
  logic signed [23:0] pos;
  logic signed [15:0] vel;
  logic airborne, ducking, land_pulse;
  logic signed [5:0]  pos5;
  logic signed [15:0] vel5;
  logic airborne5, ducking5, land_pulse5;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  mstate_t m, m5;
  longint q_pos[$], q_vel[$], q_land[$];
  longint q5_pos[$], q5_vel[$], q5_land[$];
  longint max5, min5;

  jump_physics #(.TICK_DIV(4), .POS_W(24), .VEL_W(16), .V_JUMP(6),
                 .G_NORM(2), .G_HOLD(1), .G_DIVE(4)) dut (
    .clk(clk), .rst(rst), .BTNU(btnu), .BTND(btnd),
    .pos(pos), .vel(vel), .airborne(airborne), .ducking(ducking), .land_pulse(land_pulse));

  jump_physics #(.TICK_DIV(4), .POS_W(6), .VEL_W(16), .V_JUMP(20),
                 .G_NORM(1), .G_HOLD(1), .G_DIVE(1)) dut5 (
    .clk(clk), .rst(rst), .BTNU(btnu5), .BTND(1'b0),
    .pos(pos5), .vel(vel5), .airborne(airborne5), .ducking(ducking5), .land_pulse(land_pulse5));

  always #5 clk = ~clk;

  // Flight rules written directly as arithmetic on height/velocity per clock.
  function automatic mstate_t step(mstate_t s, bit r, bit u, bit d, mparam_t p);
    mstate_t n;
    longint np, nv;
    int g;
    bit tick;
    n = s;
    n.land = 1'b0;
    n.ev = 1'b0;
    if (r) begin
      n.phase = 0; n.pos = 0; n.vel = 0; n.cyc = 0;
      n.prev = 1'b1; n.air = 1'b0; n.duck = 1'b0;
    end else begin
      tick = ((s.cyc % p.tdiv) == p.tdiv - 1);
      if (s.phase == 0) begin
        if (u && !s.prev) n.phase = 1;
      end else if (s.phase == 1) begin
        n.pos = 0; n.vel = p.vjump; n.phase = 2;
      end else if (tick) begin
        n.ev = 1'b1;
        g = d ? p.gd : ((u && s.vel > 0) ? p.gh : p.gn);
        np = s.pos + s.vel;
        nv = s.vel - g;
        if (nv < p.vmin) nv = p.vmin;
        if (np <= 0) begin
          n.pos = 0; n.vel = 0; n.land = 1'b1; n.phase = 0;
        end else begin
          n.pos = (np > p.pmax) ? p.pmax : np;
          n.vel = nv;
        end
      end
      n.air = (n.phase != 0);
      n.duck = d && (n.phase == 0);
      n.prev = u;
      n.cyc = s.cyc + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m  <= step(m,  rst, btnu,  btnd, P);
    m5 <= step(m5, rst, btnu5, 1'b0, P5);
  end

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, plus logging of per-tick results.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pos", pos, m.pos);
      check("vel", vel, m.vel);
      check("airborne", airborne, m.air);
      check("ducking", ducking, m.duck);
      check("land_pulse", land_pulse, m.land);
      check("pos5", pos5, m5.pos);
      check("vel5", vel5, m5.vel);
      check("airborne5", airborne5, m5.air);
      check("land_pulse5", land_pulse5, m5.land);
      if (m.ev) begin
        q_pos.push_back(pos); q_vel.push_back(vel); q_land.push_back(land_pulse);
      end
      if (m5.ev) begin
        q5_pos.push_back(pos5); q5_vel.push_back(vel5); q5_land.push_back(land_pulse5);
      end
      if (pos5 > max5) max5 = pos5;
      if (pos5 < min5) min5 = pos5;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_q;
    q_pos.delete(); q_vel.delete(); q_land.delete();
  endtask

  task automatic wait_ev(input int n, input int budget, input string nm);
    int k = 0;
    while (q_pos.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    check(nm, q_pos.size(), n);
  endtask

  task automatic wait_ground(input int budget, input string nm);
    int k = 0;
    while (airborne !== 1'b0 && k < budget) begin
      cyc(1);
      k++;
    end
    check(nm, airborne, 0);
  endtask

  task automatic tap;
    btnu = 1'b1;
    cyc(1);
    btnu = 1'b0;
  endtask

  task automatic chk_traj(input string nm, input longint ep[], input longint ev[]);
    for (int i = 0; i < ep.size(); i++) begin
      check({nm, "_pos"}, (i < q_pos.size()) ? q_pos[i] : -999, ep[i]);
      check({nm, "_vel"}, (i < q_vel.size()) ? q_vel[i] : -999, ev[i]);
    end
  endtask

  initial begin
    longint ep[], ev[];
    rst = 1'b1; btnu = 1'b1; btnd = 1'b0; btnu5 = 1'b0;
    max5 = 0; min5 = 0;
    cyc(3);
    chk_en = 1'b1;
    check("reset_pos", pos, 0);
    check("reset_airborne", airborne, 0);
    check("reset_land", land_pulse, 0);

    // Held through reset release: no launch.
    rst = 1'b0;
    cyc(50);
    check("t1_pos", pos, 0);
    check("t1_vel", vel, 0);
    check("t1_airborne", airborne, 0);

    // Single tap.
    btnu = 1'b0;
    cyc(2);
    clear_q();
    tap();
    wait_ev(7, 80, "t2_events");
    ep = '{6, 10, 12, 12, 10, 6, 0};
    ev = '{4, 2, 0, -2, -4, -6, 0};
    chk_traj("t2", ep, ev);
    check("t2_land_last", (q_land.size() > 6) ? q_land[6] : -1, 1);
    check("t2_land_prev", (q_land.size() > 5) ? q_land[5] : -1, 0);
    cyc(1);
    check("t2_land_once", land_pulse, 0);
    check("t2_air_after", airborne, 0);

    // Held jump: lower rise gravity, no relaunch while still held.
    cyc(3);
    clear_q();
    btnu = 1'b1;
    wait_ev(12, 120, "t3_events");
    ep = '{6, 11, 15, 18, 20, 21, 21, 19, 15, 9, 1, 0};
    ev = '{5, 4, 3, 2, 1, 0, -2, -4, -6, -8, -10, 0};
    chk_traj("t3", ep, ev);
    cyc(20);
    check("t3_no_relaunch", airborne, 0);
    check("t3_no_events", q_pos.size(), 12);
    btnu = 1'b0;
    cyc(1);
    btnu = 1'b1;
    cyc(2);
    check("t3_relaunch", airborne, 1);
    btnu = 1'b0;
    wait_ground(200, "t3_second_land");

    // Dive after the second tick.
    cyc(2);
    clear_q();
    tap();
    wait_ev(2, 40, "t4_pre");
    btnd = 1'b1;
    wait_ev(6, 60, "t4_events");
    ep = '{6, 10, 12, 10, 4, 0};
    ev = '{4, 2, -2, -6, -10, 0};
    chk_traj("t4", ep, ev);
    check("t4_ducking", ducking, 1);
    check("t4_air", airborne, 0);
    btnd = 1'b0;
    cyc(1);
    check("t4_unduck", ducking, 0);

    // Reset in mid-flight.
    cyc(2);
    clear_q();
    tap();
    wait_ev(3, 40, "t6_pre");
    rst = 1'b1;
    cyc(1);
    check("t6_pos", pos, 0);
    check("t6_vel", vel, 0);
    check("t6_air", airborne, 0);
    check("t6_land", land_pulse, 0);
    rst = 1'b0;
    cyc(3);
    check("t6_stays_idle", airborne, 0);

    // Narrow position: clamp at 31, never wrap.
    max5 = 0; min5 = 0;
    q5_pos.delete(); q5_vel.delete(); q5_land.delete();
    btnu5 = 1'b1;
    begin
      int k = 0;
      while (q5_pos.size() < 29 && k < 400) begin
        cyc(1);
        k++;
      end
    end
    check("t5_events", q5_pos.size(), 29);
    check("t5_p0", (q5_pos.size() > 2) ? q5_pos[0] : -999, 20);
    check("t5_p1", (q5_pos.size() > 2) ? q5_pos[1] : -999, 31);
    check("t5_p2", (q5_pos.size() > 2) ? q5_pos[2] : -999, 31);
    check("t5_v1", (q5_vel.size() > 2) ? q5_vel[1] : -999, 18);
    check("t5_p27", (q5_pos.size() > 28) ? q5_pos[27] : -999, 3);
    check("t5_land", (q5_land.size() > 28) ? q5_land[28] : -1, 1);
    check("t5_max", max5, 31);
    check("t5_min", min5, 0);
    cyc(10);
    check("t5_held_no_relaunch", airborne5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
